// File: rtl/vga_timing_pkg.sv
// Shared timing definitions for the VGA timing generator: standard mode
// tables, frame/line total arithmetic and elaboration-time sanity checks.
package vga_timing_pkg;

    localparam int unsigned CLK_DIV_MAX = 16;

    // One axis of a video mode, listed in scan order.
    typedef struct packed {
        int unsigned display;
        int unsigned front_porch;
        int unsigned sync;
        int unsigned back_porch;
    } axis_timing_t;

    typedef struct packed {
        int unsigned  pclk_hz;
        axis_timing_t h;
        axis_timing_t v;
        logic         hsync_pol;
        logic         vsync_pol;
    } vga_mode_t;

    // 640x480@60, nominal 25 MHz pixel clock, negative syncs.
    localparam vga_mode_t MODE_640X480_60 = '{
        pclk_hz:   25_000_000,
        h:         '{display: 640, front_porch: 16, sync: 96, back_porch: 48},
        v:         '{display: 480, front_porch: 10, sync: 2,  back_porch: 33},
        hsync_pol: 1'b0,
        vsync_pol: 1'b0
    };

    // 800x600@60, 40 MHz pixel clock, positive syncs.
    localparam vga_mode_t MODE_800X600_60 = '{
        pclk_hz:   40_000_000,
        h:         '{display: 800, front_porch: 40, sync: 128, back_porch: 88},
        v:         '{display: 600, front_porch: 1,  sync: 4,   back_porch: 23},
        hsync_pol: 1'b1,
        vsync_pol: 1'b1
    };

    function automatic int unsigned timing_total(
        input int unsigned display,
        input int unsigned front_porch,
        input int unsigned sync,
        input int unsigned back_porch
    );
        return display + front_porch + sync + back_porch;
    endfunction

    // True when a coord_w-bit counter can hold every value 0..total-1.
    function automatic bit coord_w_fits(
        input int unsigned coord_w,
        input int unsigned total
    );
        if (coord_w >= 32) begin
            return 1'b1;
        end
        return (64'(1) << coord_w) >= 64'(total);
    endfunction

    function automatic bit clk_div_valid(input int unsigned clk_div);
        return (clk_div >= 1) && (clk_div <= CLK_DIV_MAX);
    endfunction

endpackage

// File: rtl/vga_tick_div.sv
// Pixel-clock divider: emits a one-clk tick every CLK_DIV enabled clocks.
// The phase counter freezes while en is low so a resumed run keeps its phase.
module vga_tick_div
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // Next phase: advance and wrap only while enabled.
    always_comb begin
        div_d = div_q;
        if (en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
    end

    // Phase register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Gated by reset so the strobe is quiet while held in reset (CLK_DIV = 1).
    assign tick = reset && en && (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/SVGA timing generator: pixel divider, x/y scan counters,
// registered sync/visibility outputs and line/frame strobes.
// Optional macro VGA_PREFETCH_EN adds x_next/y_next/video_on_next, the
// coordinate presented after the next pixel tick.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISPLAY = MODE_640X480_60.h.display,
    parameter int unsigned H_FP      = MODE_640X480_60.h.front_porch,
    parameter int unsigned H_SYNC    = MODE_640X480_60.h.sync,
    parameter int unsigned H_BP      = MODE_640X480_60.h.back_porch,
    parameter int unsigned V_DISPLAY = MODE_640X480_60.v.display,
    parameter int unsigned V_FP      = MODE_640X480_60.v.front_porch,
    parameter int unsigned V_SYNC    = MODE_640X480_60.v.sync,
    parameter int unsigned V_BP      = MODE_640X480_60.v.back_porch,
    parameter int unsigned HSYNC_POL = 0,
    parameter int unsigned VSYNC_POL = 0,
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned COORD_W   = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               p_tick,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_end,
    output logic               frame_end
`ifdef VGA_PREFETCH_EN
    ,
    output logic [COORD_W-1:0] x_next,
    output logic [COORD_W-1:0] y_next,
    output logic               video_on_next
`endif
);

    localparam int unsigned H_TOTAL = timing_total(H_DISPLAY, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = timing_total(V_DISPLAY, V_FP, V_SYNC, V_BP);

    // Region bounds carry one extra bit so an end bound equal to 2^COORD_W
    // does not truncate to zero.
    localparam logic [COORD_W:0] H_DISP_END = (COORD_W+1)'(H_DISPLAY);
    localparam logic [COORD_W:0] H_SYNC_BEG = (COORD_W+1)'(H_DISPLAY + H_FP);
    localparam logic [COORD_W:0] H_SYNC_END = (COORD_W+1)'(H_DISPLAY + H_FP + H_SYNC);
    localparam logic [COORD_W:0] V_DISP_END = (COORD_W+1)'(V_DISPLAY);
    localparam logic [COORD_W:0] V_SYNC_BEG = (COORD_W+1)'(V_DISPLAY + V_FP);
    localparam logic [COORD_W:0] V_SYNC_END = (COORD_W+1)'(V_DISPLAY + V_FP + V_SYNC);

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

    localparam logic HS_ACT = (HSYNC_POL != 0);
    localparam logic VS_ACT = (VSYNC_POL != 0);

    if (!coord_w_fits(COORD_W, H_TOTAL)) begin : g_h_width_check
        $error("vga_timing_gen: COORD_W=%0d too narrow for H_TOTAL=%0d", COORD_W, H_TOTAL);
    end
    if (!coord_w_fits(COORD_W, V_TOTAL)) begin : g_v_width_check
        $error("vga_timing_gen: COORD_W=%0d too narrow for V_TOTAL=%0d", COORD_W, V_TOTAL);
    end
    if (!clk_div_valid(CLK_DIV)) begin : g_div_check
        $error("vga_timing_gen: CLK_DIV=%0d outside 1..%0d", CLK_DIV, CLK_DIV_MAX);
    end

    function automatic logic in_window(
        input logic [COORD_W-1:0] v,
        input logic [COORD_W:0]   lo,
        input logic [COORD_W:0]   hi
    );
        return ({1'b0, v} >= lo) && ({1'b0, v} < hi);
    endfunction

    logic               tick;
    logic [COORD_W-1:0] x_q, x_d, x_adv;
    logic [COORD_W-1:0] y_q, y_d, y_adv;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               video_on_q, video_on_d;

    vga_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_div (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .tick (tick)
    );

    // Coordinate one pixel ahead of the current one, with line/frame wrap.
    always_comb begin
        x_adv = x_q + COORD_W'(1);
        y_adv = y_q;
        if (x_q == H_LAST) begin
            x_adv = '0;
            y_adv = (y_q == V_LAST) ? '0 : y_q + COORD_W'(1);
        end
    end

    // Counters step to the look-ahead coordinate only on a pixel tick.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (tick) begin
            x_d = x_adv;
            y_d = y_adv;
        end
    end

    // Decode regions from the next-state coordinate so the registered
    // outputs line up with x/y on the same edge.
    always_comb begin
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        video_on_d = video_on_q;
        if (en) begin
            hsync_d    = in_window(x_d, H_SYNC_BEG, H_SYNC_END) ? HS_ACT : ~HS_ACT;
            vsync_d    = in_window(y_d, V_SYNC_BEG, V_SYNC_END) ? VS_ACT : ~VS_ACT;
            video_on_d = in_window(x_d, '0, H_DISP_END) && in_window(y_d, '0, V_DISP_END);
        end
    end

    // Scan position and registered timing outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q        <= '0;
            y_q        <= '0;
            hsync_q    <= ~HS_ACT;
            vsync_q    <= ~VS_ACT;
            video_on_q <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
        end
    end

    assign p_tick    = tick;
    assign x         = x_q;
    assign y         = y_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign video_on  = video_on_q;
    assign line_end  = tick && (x_q == H_LAST);
    assign frame_end = line_end && (y_q == V_LAST);

`ifdef VGA_PREFETCH_EN
    assign x_next        = x_adv;
    assign y_next        = y_adv;
    assign video_on_next = in_window(x_adv, '0, H_DISP_END) && in_window(y_adv, '0, V_DISP_END);
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three differently configured
// instances share clock, reset and enable; a pixel-index model predicts
// every output each cycle.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    always #5 clk = ~clk;

    // Instance 0: tiny mode, CLK_DIV 3, positive vsync.
    logic       hs0, vs0, vo0, pt0, le0, fe0;
    logic [4:0] x0, y0;
    // Instance 1: defaults (640x480, CLK_DIV 2).
    logic       hs1, vs1, vo1, pt1, le1, fe1;
    logic [9:0] x1, y1;
    // Instance 2: 800x600, CLK_DIV 1, positive syncs.
    logic        hs2, vs2, vo2, pt2, le2, fe2;
    logic [10:0] x2, y2;
`ifdef VGA_PREFETCH_EN
    logic [4:0]  xn0, yn0;
    logic [9:0]  xn1, yn1;
    logic [10:0] xn2, yn2;
    logic        von0, von1, von2;
`endif

    vga_timing_gen #(
        .H_DISPLAY(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_DISPLAY(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(0), .VSYNC_POL(1), .CLK_DIV(3), .COORD_W(5)
    ) u_dut0 (
        .clk(clk), .reset(rst_n), .en(en),
        .hsync(hs0), .vsync(vs0), .video_on(vo0), .p_tick(pt0),
        .x(x0), .y(y0), .line_end(le0), .frame_end(fe0)
`ifdef VGA_PREFETCH_EN
        , .x_next(xn0), .y_next(yn0), .video_on_next(von0)
`endif
    );

    vga_timing_gen u_dut1 (
        .clk(clk), .reset(rst_n), .en(en),
        .hsync(hs1), .vsync(vs1), .video_on(vo1), .p_tick(pt1),
        .x(x1), .y(y1), .line_end(le1), .frame_end(fe1)
`ifdef VGA_PREFETCH_EN
        , .x_next(xn1), .y_next(yn1), .video_on_next(von1)
`endif
    );

    vga_timing_gen #(
        .H_DISPLAY(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_DISPLAY(600), .V_FP(1),  .V_SYNC(4),   .V_BP(23),
        .HSYNC_POL(1), .VSYNC_POL(1), .CLK_DIV(1), .COORD_W(11)
    ) u_dut2 (
        .clk(clk), .reset(rst_n), .en(en),
        .hsync(hs2), .vsync(vs2), .video_on(vo2), .p_tick(pt2),
        .x(x2), .y(y2), .line_end(le2), .frame_end(fe2)
`ifdef VGA_PREFETCH_EN
        , .x_next(xn2), .y_next(yn2), .video_on_next(von2)
`endif
    );

    // Reference model: mode table plus divider phase and linear pixel index.
    int unsigned m_hd[3]  = '{16, 640, 800};
    int unsigned m_hfp[3] = '{2, 16, 40};
    int unsigned m_hsw[3] = '{3, 96, 128};
    int unsigned m_hbp[3] = '{2, 48, 88};
    int unsigned m_vd[3]  = '{6, 480, 600};
    int unsigned m_vfp[3] = '{1, 10, 1};
    int unsigned m_vsw[3] = '{2, 2, 4};
    int unsigned m_vbp[3] = '{1, 33, 23};
    int unsigned m_div[3] = '{3, 2, 1};
    bit          m_hpol[3] = '{1'b0, 1'b0, 1'b1};
    bit          m_vpol[3] = '{1'b1, 1'b0, 1'b1};

    int unsigned m_c[3];
    int unsigned m_p[3];
    bit          m_valid[3];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cnum = 0;
    logic [37:0] samp[3];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned m_ht(int i);
        return m_hd[i] + m_hfp[i] + m_hsw[i] + m_hbp[i];
    endfunction

    function automatic int unsigned m_vt(int i);
        return m_vd[i] + m_vfp[i] + m_vsw[i] + m_vbp[i];
    endfunction

    function automatic logic [37:0] pack_out(logic hs, logic vs, logic vo, logic pt,
                                             logic le, logic fe, logic [15:0] xv, logic [15:0] yv);
        return {hs, vs, vo, pt, le, fe, xv, yv};
    endfunction

    function automatic logic [37:0] obs_vec(int i);
        case (i)
            0:       return pack_out(hs0, vs0, vo0, pt0, le0, fe0, 16'(x0), 16'(y0));
            1:       return pack_out(hs1, vs1, vo1, pt1, le1, fe1, 16'(x1), 16'(y1));
            default: return pack_out(hs2, vs2, vo2, pt2, le2, fe2, 16'(x2), 16'(y2));
        endcase
    endfunction

    function automatic logic [37:0] model_vec(int i);
        int unsigned ht = m_ht(i);
        int unsigned vt = m_vt(i);
        int unsigned xv = m_p[i] % ht;
        int unsigned yv = m_p[i] / ht;
        logic tk = rst_n && en && (m_c[i] == m_div[i] - 1);
        logic le = tk && (xv == ht - 1);
        logic fe = le && (yv == vt - 1);
        logic hs = !m_hpol[i];
        logic vs = !m_vpol[i];
        logic vo = 1'b0;
        if (m_valid[i]) begin
            if (xv >= m_hd[i] + m_hfp[i] && xv < m_hd[i] + m_hfp[i] + m_hsw[i]) hs = m_hpol[i];
            if (yv >= m_vd[i] + m_vfp[i] && yv < m_vd[i] + m_vfp[i] + m_vsw[i]) vs = m_vpol[i];
            vo = (xv < m_hd[i]) && (yv < m_vd[i]);
        end
        return pack_out(hs, vs, vo, tk, le, fe, 16'(xv), 16'(yv));
    endfunction

`ifdef VGA_PREFETCH_EN
    function automatic logic [32:0] pf_obs(int i);
        case (i)
            0:       return {von0, 16'(xn0), 16'(yn0)};
            1:       return {von1, 16'(xn1), 16'(yn1)};
            default: return {von2, 16'(xn2), 16'(yn2)};
        endcase
    endfunction

    function automatic logic [32:0] pf_model(int i);
        int unsigned ht = m_ht(i);
        int unsigned pn = (m_p[i] + 1) % (ht * m_vt(i));
        int unsigned xn = pn % ht;
        int unsigned yn = pn / ht;
        return {(xn < m_hd[i]) && (yn < m_vd[i]), 16'(xn), 16'(yn)};
    endfunction
`endif

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_c[i] = 0;
            m_p[i] = 0;
            m_valid[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_c[i] = 0;
                m_p[i] = 0;
                m_valid[i] = 1'b0;
            end else if (en) begin
                if (m_c[i] == m_div[i] - 1) begin
                    m_c[i] = 0;
                    m_p[i] = (m_p[i] + 1) % (m_ht(i) * m_vt(i));
                end else begin
                    m_c[i] = m_c[i] + 1;
                end
                m_valid[i] = 1'b1;
            end
        end
    endtask

    task automatic compare_all(input string what);
        for (int i = 0; i < 3; i++) begin
            samp[i] = obs_vec(i);
            check($sformatf("%s_dut%0d", what, i), samp[i], model_vec(i));
`ifdef VGA_PREFETCH_EN
            check($sformatf("%s_pf_dut%0d", what, i), pf_obs(i), pf_model(i));
`endif
        end
    endtask

    // Drive at the falling edge, check, then advance the model at the rising edge.
    task automatic cyc(input logic en_v, input logic rst_v);
        @(negedge clk);
        en = en_v;
        rst_n = rst_v;
        #1;
        compare_all("out");
        @(posedge clk);
        model_step();
        cnum++;
    endtask

    int unsigned nle[3], tle[3], per[3], hact[3], vact[3];
    int unsigned nfe, tfe, fper, found, got;

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        model_reset();
        repeat (3) cyc(1'b0, 1'b0);
        check("rst_x0", 64'(samp[0][31:16]), 64'd0);
        check("rst_hs1", 64'(samp[1][37]), 64'd1);
        check("rst_vo2", 64'(samp[2][35]), 64'd0);

        // Release reset; the first enabled edge makes the origin visible.
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        check("first_vo0", 64'(samp[0][35]), 64'd1);
        check("first_x0", 64'(samp[0][31:16]), 64'd0);

        repeat (1500) cyc($urandom_range(0, 3) != 0, 1'b1);

        // Frame period on the small instance with en held high.
        nfe = 0; tfe = 0; fper = 0;
        for (int k = 0; k < 3000 && nfe < 2; k++) begin
            cyc(1'b1, 1'b1);
            if (samp[0][32]) begin
                if (nfe == 1) fper = cnum - tfe;
                tfe = cnum;
                nfe++;
            end
        end
        check("fe_seen0", 64'(nfe), 64'd2);
        check("fe_period0", 64'(fper), 64'(m_ht(0) * m_vt(0) * m_div[0]));

        // Line period, sync width and visible width over one full line.
        for (int i = 0; i < 3; i++) begin
            nle[i] = 0; tle[i] = 0; per[i] = 0; hact[i] = 0; vact[i] = 0;
        end
        for (int k = 0; k < 4000 && (nle[0] < 2 || nle[1] < 2 || nle[2] < 2); k++) begin
            cyc(1'b1, 1'b1);
            for (int i = 0; i < 3; i++) begin
                if (nle[i] == 1) begin
                    if (samp[i][37] == m_hpol[i]) hact[i]++;
                    if (samp[i][35]) vact[i]++;
                end
                if (samp[i][33] && nle[i] < 2) begin
                    if (nle[i] == 1) per[i] = cnum - tle[i];
                    tle[i] = cnum;
                    nle[i]++;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("le_period_dut%0d", i), 64'(per[i]), 64'(m_ht(i) * m_div[i]));
            check($sformatf("hs_width_dut%0d", i), 64'(hact[i]), 64'(m_hsw[i] * m_div[i]));
            if (i > 0) check($sformatf("vo_width_dut%0d", i), 64'(vact[i]), 64'(m_hd[i] * m_div[i]));
        end

        // Hold on the last pixel of the frame: no strobe, no wrap.
        found = 0;
        for (int k = 0; k < 2000; k++) begin
            if (m_p[0] == m_ht(0) * m_vt(0) - 1) begin
                found = 1;
                break;
            end
            cyc(1'b1, 1'b1);
        end
        check("hold_reach", 64'(found), 64'd1);
        nfe = 0;
        repeat (37) begin
            cyc(1'b0, 1'b1);
            if (samp[0][32]) nfe++;
        end
        check("hold_no_fe", 64'(nfe), 64'd0);
        check("hold_x", 64'(samp[0][31:16]), 64'd22);
        check("hold_y", 64'(samp[0][15:0]), 64'd9);
        got = 0;
        for (int k = 0; k < 6 && got == 0; k++) begin
            cyc(1'b1, 1'b1);
            if (samp[0][32]) got = 1;
        end
        check("resume_fe", 64'(got), 64'd1);
        cyc(1'b1, 1'b1);
        check("wrap_x", 64'(samp[0][31:16]), 64'd0);
        check("wrap_y", 64'(samp[0][15:0]), 64'd0);

        // Asynchronous reset mid-frame.
        found = 0;
        for (int k = 0; k < 2000; k++) begin
            if (m_p[0] == 5 * m_ht(0) + 11) begin
                found = 1;
                break;
            end
            cyc(1'b1, 1'b1);
        end
        check("mid_reach", 64'(found), 64'd1);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all("async_rst");
        check("async_x0", 64'(samp[0][31:16]), 64'd0);
        check("async_y0", 64'(samp[0][15:0]), 64'd0);
        @(posedge clk);
        model_step();
        cnum++;
        repeat (2) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        check("rel_vo0", 64'(samp[0][35]), 64'd1);
        check("rel_x0", 64'(samp[0][31:16]), 64'd0);

        repeat (1000) cyc($urandom_range(0, 4) != 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/SVGA timing generator, successor to the fixed 640x480 sync block. All porch, sync and display widths are parameters. Adds a configurable pixel-clock divider, per-axis sync polarity, a run/hold enable, and line/frame strobes. Sits between the system clock and the pixel pipeline (frame buffer read, pattern generator, RGB output registers).

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FP, 16, horizontal front porch, in pixels
H_SYNC, 96, horizontal sync width, in pixels
H_BP, 48, horizontal back porch, in pixels
V_DISPLAY, 480, visible lines per frame
V_FP, 10, vertical front porch, in lines
V_SYNC, 2, vertical sync width, in lines
V_BP, 33, vertical back porch, in lines
HSYNC_POL, 0, active level of hsync (0 = active-low)
VSYNC_POL, 0, active level of vsync (0 = active-low)
CLK_DIV, 2, clk cycles per pixel (1..16)
COORD_W, 10, width of the x and y coordinate outputs

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
en  in  1  1 = run; 0 = hold all counters
hsync  out  1  horizontal sync, polarity set by HSYNC_POL
vsync  out  1  vertical sync, polarity set by VSYNC_POL
video_on  out  1  current pixel lies in the visible area
p_tick  out  1  one-clk pixel strobe; counters advance on it
x  out  COORD_W  horizontal pixel count
y  out  COORD_W  vertical line count
line_end  out  1  one-clk pulse on the last pixel of each line
frame_end  out  1  one-clk pulse on the last pixel of each frame

Behaviour:
- Totals: H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP; V_TOTAL = V_DISPLAY+V_FP+V_SYNC+V_BP.
- Elaboration error if 2^COORD_W < H_TOTAL or 2^COORD_W < V_TOTAL, or if CLK_DIV is outside 1..16.
- Region order per axis: display, front porch, sync, back porch.
  - Sync active for H_DISPLAY+H_FP <= x < H_DISPLAY+H_FP+H_SYNC.
  - Same rule vertically with the V_* parameters.
- Reset (reset = 0), asynchronous:
  - Divider count = 0, x = 0, y = 0.
  - p_tick, video_on, line_end, frame_end = 0.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
- Divider: counts 0..CLK_DIV-1 while en = 1.
  - p_tick = en && (div == CLK_DIV-1), combinational.
  - CLK_DIV = 1: p_tick = en.
- Counters, on a clk edge with p_tick = 1:
  - x wraps from H_TOTAL-1 to 0, otherwise increments.
  - y increments only when x wraps; y wraps from V_TOTAL-1 to 0.
- line_end = p_tick && x == H_TOTAL-1.
- frame_end = line_end && y == V_TOTAL-1.
- hsync, vsync, video_on are registers loaded every clk from the next-state x/y. They are therefore cycle-aligned with x/y and have no lag.
- First clk edge after reset release: video_on becomes 1 because x = y = 0.
- en = 0:
  - Divider, x, y and all registered outputs hold their values.
  - p_tick, line_end and frame_end are 0.
  - Resuming continues from the held divider phase.
- en deasserted on the same edge as a wrap: no wrap occurs (p_tick = 0).
- Reset asserted mid-frame: immediate return to the reset values; no partial-line completion.

Optional Feature:
Macro VGA_PREFETCH_EN.
- Defined: adds outputs x_next, y_next (COORD_W each) and video_on_next (1). These give the coordinate and visibility that will be presented after the next p_tick, so a synchronous RAM with 1-pixel latency can be addressed ahead of time. Wrap rules are the same as for x/y.
- Undefined: these ports and their logic are absent.

Decomposition:
- Package vga_timing_pkg:
  - Mode constants for 640x480@25 MHz and 800x600@40 MHz.
  - Function computing the total from display, porch and sync widths.
  - Function checking COORD_W adequacy.
- Sub-module vga_tick_div (parameter CLK_DIV; ports clk, reset, en, tick) implements the divider.
- Counters, compare logic and output registers stay in vga_timing_gen.

Test Plan:
- Defaults, en = 1, one full frame: 800 pixels per line, 525 lines, hsync low for x = 656..751, vsync low for y = 490..491, video_on high only for x < 640 and y < 480.
- Counting check: frame_end pulses once every 800*525*2 = 840000 clk cycles; line_end pulses every 1600 clk cycles.
- CLK_DIV = 1, HSYNC_POL = 1, 800x600 (FP 40, SYNC 128, BP 88): H_TOTAL = 1056, hsync high for x = 840..967.
- en dropped for 37 clk at x = 799, y = 524: x/y hold and no frame_end fires; frame_end fires, and x, y wrap to 0, at the first p_tick after en returns.
- reset pulsed low at x = 300, y = 200: outputs take their reset values asynchronously (before the next clk edge); first edge after release gives video_on = 1, x = 0.
- VGA_PREFETCH_EN defined: x_next equals x one pixel later at every p_tick, including the 799 -> 0 and y 524 -> 0 wraps.
